// File: rtl/tt_bist_pkg.sv
// Shared types and the LFSR/MISR step function for the BIST harness.
package tt_bist_pkg;

    // Widest register the step function supports.
    localparam int unsigned MaxWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } bist_state_e;

    // Fibonacci shift with parity feedback into bit 0, then XOR in a vector.
    // din = 0 gives the plain LFSR step; din = response gives the MISR step.
    // Callers zero-extend narrower state/taps, so the upper bits do not
    // disturb the parity, and they keep only their low WIDTH bits.
    function automatic logic [MaxWidth-1:0] lfsr_step(input logic [MaxWidth-1:0] state,
                                                      input logic [MaxWidth-1:0] taps,
                                                      input logic [MaxWidth-1:0] din);
        return {state[MaxWidth-2:0], ^(state & taps)} ^ din;
    endfunction

endpackage

// File: rtl/tt_lfsr_reg.sv
// WIDTH-bit LFSR/MISR register with synchronous load and step enable.
module tt_lfsr_reg
    import tt_bist_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] xor_in_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0]    q_q, q_d;
    logic [MaxWidth-1:0] step_full;
    logic                unused_step;

    // Next step value; only the low WIDTH bits are meaningful.
    always_comb begin
        step_full   = lfsr_step(MaxWidth'(q_q), MaxWidth'(TAPS), MaxWidth'(xor_in_i));
        unused_step = ^step_full;
    end

    // Load has priority over stepping.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (en_i) begin
            q_d = step_full[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tt_bist_harness.sv
// BIST harness: LFSR stimulus, MISR response compaction, start/done/pass handshake.
module tt_bist_harness
    import tt_bist_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
    parameter logic [WIDTH-1:0] SEED        = 8'h01,
    parameter int unsigned      NUM_VECTORS = 255,
    parameter int unsigned      LATENCY     = 1,
    parameter logic [WIDTH-1:0] GOLDEN      = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] resp_in,
    output logic [WIDTH-1:0] stim_out,
    output logic             stim_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int unsigned CntW = $clog2(NUM_VECTORS + 1);
    localparam int unsigned DlyW = (LATENCY > 0) ? LATENCY : 1;

    bist_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      flush_q, flush_d;
    logic [DlyW-1:0] dly_q, dly_d;
    logic [WIDTH-1:0] lfsr_q, misr_q;
    logic            lfsr_en, lfsr_load, misr_en, misr_load;
    logic            resp_valid;

    // A response is due LATENCY cycles after its stimulus was valid.
    always_comb begin
        resp_valid = (LATENCY == 0) ? stim_valid : dly_q[DlyW-1];
    end

    // Next state, counters and register controls. abort beats ena and start.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        dly_d     = dly_q;
        lfsr_en   = 1'b0;
        lfsr_load = 1'b0;
        misr_en   = 1'b0;
        misr_load = 1'b0;
        if (abort) begin
            state_d = StIdle;
            // Drop in-flight responses so a held MISR is not touched later.
            dly_d   = '0;
        end else if (ena) begin
            dly_d   = (dly_q << 1) | DlyW'(stim_valid);
            misr_en = resp_valid;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d   = StRun;
                        cnt_d     = '0;
                        dly_d     = '0;
                        lfsr_load = 1'b1;
                        misr_load = 1'b1;
                    end
                end
                StRun: begin
                    lfsr_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntW'(NUM_VECTORS - 1)) begin
                        state_d = (LATENCY > 0) ? StFlush : StDone;
                        flush_d = '0;
                    end
                end
                StFlush: begin
                    if (flush_q == 3'(LATENCY - 1)) begin
                        state_d = StDone;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM, counters and valid delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flush_q <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            dly_q   <= dly_d;
        end
    end

    tt_lfsr_reg #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .RESET_VAL (SEED)
    ) u_stim (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (lfsr_en),
        .load_i     (lfsr_load),
        .load_val_i (SEED),
        .xor_in_i   ('0),
        .q_o        (lfsr_q)
    );

    tt_lfsr_reg #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .RESET_VAL ('0)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (misr_en),
        .load_i     (misr_load),
        .load_val_i ('0),
        .xor_in_i   (resp_in),
        .q_o        (misr_q)
    );

    // Outputs decode directly from registered state.
    always_comb begin
        stim_out   = lfsr_q;
        stim_valid = (state_q == StRun);
        busy       = (state_q == StRun) || (state_q == StFlush);
        done       = (state_q == StDone);
        pass       = done && (misr_q == GOLDEN);
        signature  = misr_q;
    end

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed bench for tt_bist_harness, WIDTH=4 / TAPS=1001 / 15 vectors / LATENCY=1.
module tb_tt_bist_harness;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] resp_in;
    logic [3:0] stim_out, signature;
    logic       stim_valid, busy, done, pass;
    logic [3:0] g5_stim_out, g5_signature;
    logic       g5_stim_valid, g5_busy, g5_done, g5_pass;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Hand-derived x^4+x^3 style sequence from seed 1.
    logic [3:0] vec [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    // Datapath stand-in: one-cycle register, stalled by ena, optional fault on vector 7 (value 5).
    logic       resp_sel = 1'b0;
    logic       fault_en = 1'b0;
    logic [3:0] dp_q;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_q <= 4'h0;
        else if (ena) dp_q <= stim_out ^ {3'b000, fault_en && stim_valid && (stim_out == 4'h5)};
    end

    assign resp_in = resp_sel ? dp_q : 4'h0;

    tt_bist_harness #(
        .WIDTH(4), .TAPS(4'b1001), .SEED(4'b0001), .NUM_VECTORS(15), .LATENCY(1), .GOLDEN(4'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort), .resp_in(resp_in),
        .stim_out(stim_out), .stim_valid(stim_valid), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
    );

    tt_bist_harness #(
        .WIDTH(4), .TAPS(4'b1001), .SEED(4'b0001), .NUM_VECTORS(15), .LATENCY(1), .GOLDEN(4'h5)
    ) dut_g5 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort), .resp_in(resp_in),
        .stim_out(g5_stim_out), .stim_valid(g5_stim_valid), .busy(g5_busy), .done(g5_done),
        .pass(g5_pass), .signature(g5_signature)
    );

    // Software MISR over the known vector list, optional bit-0 flip on vector 7.
    function automatic logic [3:0] misr_model(input logic fault);
        logic [3:0] m = 4'h0;
        logic [3:0] r;
        for (int i = 0; i < 15; i++) begin
            r = vec[i];
            if (fault && i == 7) r = r ^ 4'h1;
            m = {m[2:0], m[0] ^ m[3]} ^ r;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse start, then wait for done; cyc counts cycles after the start sample.
    task automatic run_to_done(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        ena = 1'b1;
        repeat (2) tick();
        check("rst_stim_out", stim_out, 4'h1);
        check("rst_stim_valid", stim_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_signature", signature, 4'h0);
        rst_n = 1'b1;
        tick();

        // Stimulus sequence and done timing, responses tied to zero.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("seq_valid", stim_valid, 1'b1);
            check($sformatf("seq_vec%0d", i), stim_out, vec[i]);
            tick();
        end
        check("flush_valid", stim_valid, 1'b0);
        check("flush_busy", busy, 1'b1);
        check("flush_done", done, 1'b0);
        tick();
        check("done_at_17", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("zero_sig", signature, 4'h0);
        check("zero_pass", pass, 1'b1);
        check("g5_pass", g5_pass, 1'b0);

        // Loopback through the one-cycle datapath.
        resp_sel = 1'b1;
        run_to_done(cyc);
        check("loop_cycles", cyc, 17);
        check("loop_sig_model", signature, misr_model(1'b0));
        check("loop_sig_const", signature, 4'h8);
        check("loop_pass", pass, 1'b0);

        // Single-bit fault on vector 7.
        fault_en = 1'b1;
        run_to_done(cyc);
        fault_en = 1'b0;
        check("fault_sig_model", signature, misr_model(1'b1));
        check("fault_sig_const", signature, 4'hD);
        check("fault_pass", pass, 1'b0);

        // Three-cycle stall while v4 is on the bus; MISR has absorbed v0..v2.
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        repeat (4) begin
            tick();
            cyc++;
        end
        check("pre_stall_vec", stim_out, vec[4]);
        ena = 1'b0;
        repeat (3) begin
            tick();
            cyc++;
            check("stall_vec", stim_out, vec[4]);
            check("stall_valid", stim_valid, 1'b1);
            check("stall_sig", signature, 4'h7);
        end
        ena = 1'b1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("stall_cycles", cyc, 20);
        check("stall_sig_final", signature, misr_model(1'b0));

        // Abort on vector 5, then a fresh run.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort_at_vec5", stim_out, vec[5]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", stim_valid, 1'b0);
        check("abort_done", done, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_first_vec", stim_out, 4'h1);
        check("restart_valid", stim_valid, 1'b1);
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("restart_cycles", cyc, 17);
        check("restart_sig", signature, misr_model(1'b0));

        // Asynchronous reset in FLUSH, observed before any clock edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("pre_rst_flush_busy", busy, 1'b1);
        check("pre_rst_flush_valid", stim_valid, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stim_out", stim_out, 4'h1);
        check("arst_signature", signature, 4'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_pass", pass, 1'b0);
        check("arst_valid", stim_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done", done, 1'b0);
        run_to_done(cyc);
        check("post_rst_cycles", cyc, 17);
        check("post_rst_sig", signature, misr_model(1'b0));

        // start from DONE restarts a full run.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("from_done_first_vec", stim_out, 4'h1);
        check("from_done_busy", busy, 1'b1);
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("from_done_cycles", cyc, 17);
        check("from_done_sig", signature, misr_model(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
